// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA scanout path.
// 640x480@60 timing, 320x240 RGB332 framebuffer pages.
package vga_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int PAGE_SIZE = FB_W * FB_H;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = 800;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = 525;

  typedef logic [7:0] rgb332_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DONE
  } swap_state_t;

  // MSB replication keeps full-scale codes at full scale
  function automatic rgb444_t rgb_expand(input rgb332_t p);
    rgb444_t c;
    c.r = {p[7:5], p[7]};
    c.g = {p[4:2], p[4]};
    c.b = {p[1:0], p[1:0]};
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// L-deep shift line carrying hsync, vsync and visible
// so they leave alongside the pixel they belong to.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int L = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hs,
  input  logic vs,
  input  logic vis,
  output logic hs_d,
  output logic vs_d,
  output logic vis_d,
  output logic vs_pre
);

  logic [L-1:0] hs_sr;
  logic [L-1:0] vs_sr;
  logic [L-1:0] vis_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sr  <= '1;
      vs_sr  <= '1;
      vis_sr <= '0;
    end else begin
      hs_sr  <= {hs_sr[L-2:0], hs};
      vs_sr  <= {vs_sr[L-2:0], vs};
      vis_sr <= {vis_sr[L-2:0], vis};
    end
  end

  assign hs_d   = hs_sr[L-1];
  assign vs_d   = vs_sr[L-1];
  assign vis_d  = vis_sr[L-1];
  assign vs_pre = vs_sr[L-2];

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: address gen, RGB332->444 expand,
// sync alignment and vsync-locked page flipping.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int FB_W      = vga_pkg::FB_W,
  parameter int FB_H      = vga_pkg::FB_H,
  parameter int PAGE_SIZE = vga_pkg::PAGE_SIZE,
  parameter int ADDR_W    = 18,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        px_x,
  input  logic [8:0]        px_y,
  input  logic              visible,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_page,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [7:0]        fb_rd_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start
);

  localparam int L = RD_LAT + 2;

  // A misconfigured geometry or latency never fetches
  localparam logic GEOM_OK = (FB_W * FB_H == PAGE_SIZE)
                          && (RD_LAT >= 1) && (RD_LAT <= 3);

  swap_state_t state;
  swap_state_t state_nx;
  logic        vs_prev;
  logic        vs_fall;
  logic        do_swap;

  logic [ADDR_W-1:0] x_w;
  logic [ADDR_W-1:0] y_w;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr_nx;

  rgb444_t pix;
  logic    vis_d;
  logic    vs_pre;

  assign x_w  = ADDR_W'(px_x);
  assign y_w  = ADDR_W'(px_y);
  assign base = front_page ? ADDR_W'(PAGE_SIZE) : '0;

  // y*320 as y*256 + y*64
  assign addr_nx = base + (y_w << 8) + (y_w << 6) + x_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_rd_en   <= 1'b0;
      fb_rd_addr <= '0;
    end else begin
      fb_rd_en <= visible & GEOM_OK;
      if (visible) begin
        fb_rd_addr <= addr_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix <= '0;
    end else begin
      pix <= rgb_expand(fb_rd_data);
    end
  end

  assign vga_r = vis_d ? pix.r : 4'h0;
  assign vga_g = vis_d ? pix.g : 4'h0;
  assign vga_b = vis_d ? pix.b : 4'h0;

  vga_sync_delay #(
    .L(L)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .hs    (hsync_in),
    .vs    (vsync_in),
    .vis   (visible),
    .hs_d  (vga_hs),
    .vs_d  (vga_vs),
    .vis_d (vis_d),
    .vs_pre(vs_pre)
  );

  // Registered so it lands on the same cycle vga_vs falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= vga_vs & ~vs_pre;
    end
  end

  assign vs_fall = vs_prev & ~vsync_in;

  always_comb begin
    state_nx = state;
    do_swap  = 1'b0;
    unique case (state)
      IDLE: begin
        if (swap_req) state_nx = ARMED;
      end
      ARMED: begin
        if (!swap_req) begin
          state_nx = IDLE;
        end else if (vs_fall) begin
          state_nx = DONE;
          do_swap  = 1'b1;
        end
      end
      DONE: begin
        if (!swap_req) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vs_prev    <= 1'b1;
      front_page <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      state      <= state_nx;
      vs_prev    <= vsync_in;
      front_page <= front_page ^ do_swap;
      swap_ack   <= do_swap;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout, RD_LAT=1 and RD_LAT=3
// side by side on a shortened frame.
module tb_vga_scanout;

  localparam int PG    = 76800;
  localparam int MEMSZ = 2 * PG;
  localparam int H_VIS = 40;
  localparam int HS0   = 44;
  localparam int HS1   = 52;
  localparam int H_TOT = 60;
  localparam int V_VIS = 8;
  localparam int VS0   = 10;
  localparam int VS1   = 12;
  localparam int V_TOT = 15;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  localparam exp_t RST_ITEM = '{hs: 1'b1, vs: 1'b1, rgb: 12'h0};
  localparam logic [63:0] RST_EXP =
    64'({1'b1, 1'b1, 12'h0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0});

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  px_x = '0;
  logic [8:0]  px_y = '0;
  logic        visible = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        swap_req = 1'b0;

  logic        swap_ack1, swap_ack3;
  logic        front_page1, front_page3;
  logic        fb_rd_en1, fb_rd_en3;
  logic [17:0] fb_rd_addr1, fb_rd_addr3;
  logic [7:0]  fb_rd_data1, fb_rd_data3;
  logic [3:0]  vga_r1, vga_g1, vga_b1;
  logic [3:0]  vga_r3, vga_g3, vga_b3;
  logic        vga_hs1, vga_vs1, vga_hs3, vga_vs3;
  logic        frame_start1, frame_start3;

  logic [7:0]  mem [MEMSZ];
  logic [7:0]  p1;
  logic [7:0]  p3 [3];

  exp_t        q1 [$];
  exp_t        q3 [$];
  logic [1:0]  aq [$];

  int total = 0;
  int bad = 0;
  int fs_cnt1 = 0;
  int fs_cnt3 = 0;
  int ack_cnt = 0;
  logic pv1 = 1'b1;
  logic pv3 = 1'b1;
  logic prev_vs_drv = 1'b1;
  logic fp_drv = 1'b0;
  logic swap_pending = 1'b0;
  int   last_addr = 0;

  always #20 clk = ~clk;

  vga_scanout #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .px_x(px_x), .px_y(px_y),
    .visible(visible), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .swap_req(swap_req), .swap_ack(swap_ack1),
    .front_page(front_page1), .fb_rd_en(fb_rd_en1),
    .fb_rd_addr(fb_rd_addr1), .fb_rd_data(fb_rd_data1),
    .vga_r(vga_r1), .vga_g(vga_g1), .vga_b(vga_b1),
    .vga_hs(vga_hs1), .vga_vs(vga_vs1), .frame_start(frame_start1)
  );

  vga_scanout #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .px_x(px_x), .px_y(px_y),
    .visible(visible), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .swap_req(swap_req), .swap_ack(swap_ack3),
    .front_page(front_page3), .fb_rd_en(fb_rd_en3),
    .fb_rd_addr(fb_rd_addr3), .fb_rd_data(fb_rd_data3),
    .vga_r(vga_r3), .vga_g(vga_g3), .vga_b(vga_b3),
    .vga_hs(vga_hs3), .vga_vs(vga_vs3), .frame_start(frame_start3)
  );

  function automatic logic [7:0] rd(input logic [17:0] a);
    return (int'(a) < MEMSZ) ? mem[int'(a)] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (fb_rd_en1) p1 <= rd(fb_rd_addr1);
    if (fb_rd_en3) p3[0] <= rd(fb_rd_addr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign fb_rd_data1 = p1;
  assign fb_rd_data3 = p3[2];

  function automatic logic [11:0] exp_rgb(input logic [7:0] p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int x, input int y, input logic vis,
                       input logic hs, input logic vs,
                       input logic [12:0] force_c = 13'h0);
    exp_t e;
    logic sw;
    px_x = 10'(x);
    px_y = 9'(y);
    visible = vis;
    hsync_in = hs;
    vsync_in = vs;
    if (vis) last_addr = (fp_drv ? PG : 0) + y * 320 + x;
    e.hs = hs;
    e.vs = vs;
    if (force_c[12]) e.rgb = force_c[11:0];
    else e.rgb = vis ? exp_rgb(mem[last_addr]) : 12'h0;
    q1.push_back(e);
    q3.push_back(e);
    sw = prev_vs_drv & ~vs & swap_pending;
    prev_vs_drv = vs;
    if (sw) begin
      fp_drv = ~fp_drv;
      swap_pending = 1'b0;
    end
    aq.push_back({sw, fp_drv});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    visible = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    px_x = 10'd77;
    px_y = 9'd33;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst1", 64'({vga_hs1, vga_vs1, vga_r1, vga_g1, vga_b1,
          fb_rd_en1, fb_rd_addr1, front_page1, swap_ack1,
          frame_start1}), RST_EXP);
      chk("rst3", 64'({vga_hs3, vga_vs3, vga_r3, vga_g3, vga_b3,
          fb_rd_en3, fb_rd_addr3, front_page3, swap_ack3,
          frame_start3}), RST_EXP);
      @(posedge clk);
      #1;
    end
    q1.delete();
    q3.delete();
    aq.delete();
    for (int i = 0; i < 3; i++) q1.push_back(RST_ITEM);
    for (int i = 0; i < 5; i++) q3.push_back(RST_ITEM);
    aq.push_back(2'b00);
    pv1 = 1'b1;
    pv3 = 1'b1;
    prev_vs_drv = 1'b1;
    fp_drv = 1'b0;
    swap_pending = 1'b0;
    swap_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input int ev_line, input logic ev_req,
                           input logic ev_pend);
    logic v_on;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        if (v == ev_line && h == 0) begin
          swap_req = ev_req;
          swap_pending = ev_pend;
        end
        v_on = (h < H_VIS) && (v < V_VIS);
        drive(v_on ? h / 2 : 0, v_on ? v / 2 : 0, v_on,
              !(h >= HS0 && h < HS1), !(v >= VS0 && v < VS1));
      end
    end
  endtask

  initial begin
    exp_t e;
    logic [1:0] a;
    logic fs_e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (q1.size() > 3) begin
          e = q1.pop_front();
          fs_e = pv1 & ~e.vs;
          pv1 = e.vs;
          chk("out1", 64'({frame_start1, vga_hs1, vga_vs1, vga_r1,
              vga_g1, vga_b1}), 64'({fs_e, e.hs, e.vs, e.rgb}));
        end
        if (q3.size() > 5) begin
          e = q3.pop_front();
          fs_e = pv3 & ~e.vs;
          pv3 = e.vs;
          chk("out3", 64'({frame_start3, vga_hs3, vga_vs3, vga_r3,
              vga_g3, vga_b3}), 64'({fs_e, e.hs, e.vs, e.rgb}));
        end
        if (aq.size() > 1) begin
          a = aq.pop_front();
          chk("swap1", 64'({swap_ack1, front_page1}), 64'(a));
          chk("swap3", 64'({swap_ack3, front_page3}), 64'(a));
        end
        if (frame_start1) fs_cnt1++;
        if (frame_start3) fs_cnt3++;
        if (swap_ack1) ack_cnt++;
      end
    end
  end

  initial begin
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'(i ^ (i >> 8));
    mem[965] = 8'hE0;
    mem[966] = 8'h1C;
    mem[967] = 8'h03;
    mem[968] = 8'hFF;

    do_reset(5);
    run_frame(-1, 1'b0, 1'b0);

    for (int h = 0; h < 30; h++) drive(h / 2, 0, 1'b1, 1'b1, 1'b1);
    do_reset(5);

    drive(319, 239, 1'b1, 1'b1, 1'b1);
    chk("addr_max1", 64'({fb_rd_en1, fb_rd_addr1}), 64'({1'b1, 18'd76799}));
    chk("addr_max3", 64'({fb_rd_en3, fb_rd_addr3}), 64'({1'b1, 18'd76799}));
    drive(5, 3, 1'b1, 1'b1, 1'b1, 13'h1F00);
    chk("addr_p0_1", 64'({fb_rd_en1, fb_rd_addr1}), 64'({1'b1, 18'd965}));
    chk("addr_p0_3", 64'({fb_rd_en3, fb_rd_addr3}), 64'({1'b1, 18'd965}));
    drive(6, 3, 1'b1, 1'b1, 1'b1, 13'h10F0);
    drive(7, 3, 1'b1, 1'b1, 1'b1, 13'h100F);
    drive(8, 3, 1'b1, 1'b1, 1'b1, 13'h1FFF);
    drive(8, 3, 1'b0, 1'b1, 1'b1, 13'h1000);
    chk("addr_hold1", 64'({fb_rd_en1, fb_rd_addr1}), 64'({1'b0, 18'd968}));
    chk("addr_hold3", 64'({fb_rd_en3, fb_rd_addr3}), 64'({1'b0, 18'd968}));
    for (int i = 0; i < 6; i++) drive(0, 0, 1'b0, 1'b1, 1'b1);

    fs_cnt1 = 0;
    fs_cnt3 = 0;
    ack_cnt = 0;
    run_frame(-1, 1'b0, 1'b0);
    run_frame(2, 1'b1, 1'b1);
    drive(5, 3, 1'b1, 1'b1, 1'b1);
    chk("addr_p1_1", 64'({fb_rd_en1, fb_rd_addr1}), 64'({1'b1, 18'd77765}));
    chk("addr_p1_3", 64'({fb_rd_en3, fb_rd_addr3}), 64'({1'b1, 18'd77765}));
    run_frame(-1, 1'b1, 1'b0);
    run_frame(-1, 1'b1, 1'b0);
    run_frame(2, 1'b0, 1'b0);
    run_frame(2, 1'b1, 1'b1);
    run_frame(1, 1'b0, 1'b0);
    run_frame(12, 1'b1, 1'b0);
    run_frame(3, 1'b0, 1'b0);
    run_frame(-1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(0, 0, 1'b0, 1'b1, 1'b1);

    chk("fs_count1", 64'(fs_cnt1), 64'd10);
    chk("fs_count3", 64'(fs_cnt3), 64'd10);
    chk("ack_count", 64'(ack_cnt), 64'd2);
    chk("fp_final", 64'({front_page1, front_page3}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
